// File: rtl/adder_4bit_josh_pkg.sv
// Package: adder_4bit_josh_pkg
//
// Purpose: shared constants for the small-datapath adder.
//   ADDER_W : default operand/sum width of adder_4bit_josh.

package adder_4bit_josh_pkg;

    localparam int ADDER_W = 4;

endpackage : adder_4bit_josh_pkg

// File: rtl/adder_4bit_josh_full_adder_cell.sv
// Module: full_adder_cell
//
// Purpose: one-bit combinational full adder, the ripple stage of adder_4bit_josh.
//
// Ports:
//   a    in  1  operand bit A
//   b    in  1  operand bit B
//   cin  in  1  carry from the previous (less significant) cell
//   s    out 1  sum bit
//   cout out 1  carry to the next (more significant) cell

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (b & cin) | (a & cin);

endmodule : full_adder_cell

// File: rtl/adder_4bit_josh.sv
// Module: adder_4bit_josh
//
// Purpose: unsigned ripple-carry adder with a registered result. The sum and
//   carry-out appear one clock after the operands are sampled; carry-in is 0.
//   A new operand pair is accepted every cycle.
//
// Ports:
//   clk in  1      clock, rising edge
//   rst in  1      synchronous reset, active-high; clears ss and cc
//   aa  in  WIDTH  operand A, unsigned
//   bb  in  WIDTH  operand B, unsigned
//   ss  out WIDTH  registered (aa + bb) mod 2^WIDTH
//   cc  out 1      registered carry-out (bit WIDTH of aa + bb)

module adder_4bit_josh
    import adder_4bit_josh_pkg::*;
#(
    parameter int WIDTH = ADDER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] aa,
    input  logic [WIDTH-1:0] bb,
    output logic [WIDTH-1:0] ss,
    output logic             cc
);

    // w_carry[i] is the carry into cell i; w_carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_fa (
                .a    (aa[gi]),
                .b    (bb[gi]),
                .cin  (w_carry[gi]),
                .s    (w_sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    // Reset has priority over the operands sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry[WIDTH];
        end
    end

    assign ss = r_sum;
    assign cc = r_carry;

endmodule : adder_4bit_josh

// File: tb/tb_adder_4bit_josh.sv
module tb_adder_4bit_josh;

    logic       clk;
    logic       rst;
    logic [3:0] aa;
    logic [3:0] bb;
    logic [3:0] ss;
    logic       cc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    bit   drv_done = 0;

    adder_4bit_josh dut (
        .clk (clk),
        .rst (rst),
        .aa  (aa),
        .bb  (bb),
        .ss  (ss),
        .cc  (cc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one operand pair for the next rising edge and record what the
    // registered output must be after that edge: plain integer addition, or
    // zero while reset is asserted.
    task automatic drive(input logic r, input int a, input int b, input string name);
        exp_t e;
        int   sum;
        @(negedge clk);
        rst = r;
        aa  = 4'(a);
        bb  = 4'(b);
        sum = r ? 0 : (a + b);
        e.exp  = 5'(sum);
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: every cycle the adder presents a result; compare it against
    // the oldest outstanding expectation.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            total++;
            if ({cc, ss} !== e.exp) begin
                bad++;
                $display("FAIL %s: got cc=%b ss=%0d, expected cc=%b ss=%0d",
                         e.name, cc, ss, e.exp[4], e.exp[3:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        aa  = 4'hF;
        bb  = 4'hF;

        // reset holds outputs at zero despite non-zero operands
        drive(1, 15, 15, "reset_0");
        drive(1, 15, 15, "reset_1");

        drive(0, 3, 5,   "add_3_5");
        drive(0, 15, 1,  "wrap_15_1");
        drive(0, 15, 15, "max_15_15");
        drive(0, 0, 0,   "zero_0_0");

        // reset mid-stream wins, then the held operands come through
        drive(0, 9, 9,   "pre_rst_9_9");
        drive(1, 9, 9,   "mid_rst");
        drive(0, 9, 9,   "post_rst_9_9");

        for (int i = 0; i < 100; i++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            drive(0, ra, rb, $sformatf("rand_%0d", i));
        end

        drive(0, 0, 15, "edge_0_15");
        drive(0, 8, 8,  "edge_8_8");
        drive(0, 7, 8,  "edge_7_8");
        drive(0, 1, 15, "edge_1_15");
        drive_done_wait();
    end

    task automatic drive_done_wait();
        int budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb_q.size());
        end
        drv_done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

endmodule : tb_adder_4bit_josh
